rf_wb_sched: RTL
================

Name: rf_wb_sched

Overview:
Write-port scheduler and load scoreboard for the 64-bit register file.
- Zeroes all registers after reset with a sequenced sweep.
- Arbitrates the single register-file write port between ALU writeback and data-cache load acks.
- Tracks outstanding load destinations and raises decode stall on RAW hazards.
- Sits between the execute/memory stages and regfile; drives the regfile we/rd/dest/dest_long inputs.

Parameters:
NREGS, 32, number of architectural registers (power of 2)
RW, 5, register index width (log2 NREGS)
XLEN, 64, data width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
alu_valid  in  1  ALU writeback request
alu_rd  in  RW  ALU destination
alu_data  in  XLEN  ALU result
alu_long  in  1  1 = full-width write, 0 = low 32 bits only
alu_retry  out  1  ALU request not accepted this cycle
ld_issue_valid  in  1  load issued to dcache
ld_issue_rd  in  RW  load destination
ld_issue_retry  out  1  load issue not accepted
dcache_ack_valid  in  1  load data return (cannot be retried)
dcache_ack_rd  in  RW  load destination
dcache_ack_data  in  XLEN  load data
dec_valid  in  1  decode has an instruction
dec_rs1  in  RW  decode source 1
dec_rs2  in  RW  decode source 2
dec_stall  out  1  decode must hold
rf_we  out  1  regfile write enable (registered)
rf_rd  out  RW  regfile write index (registered)
rf_dest  out  XLEN  regfile write data (registered)
rf_dest_long  out  1  regfile full-width write (registered)
init_busy  out  1  init sweep in progress
ld_pending  out  1  any load outstanding

Behaviour:
- Reset (reset=0, async):
  - state=INIT, init counter=0, scoreboard=0, rf_we=0, rf_rd=0, rf_dest=0, rf_dest_long=0.
  - init_busy=1, alu_retry=1, ld_issue_retry=1, dec_stall=1, ld_pending=0.
  - Reset asserted mid-operation discards all pending state and restarts INIT.
- INIT:
  - Each cycle registers rf_we=1, rf_rd=cnt, rf_dest=0, rf_dest_long=1; cnt increments.
  - After writing index NREGS-1, go to RUN. Sweep takes NREGS cycles after reset release.
  - All retries and dec_stall are held at 1.
  - dcache acks are ignored (no load can be outstanding).
- RUN, write-port arbitration (result registered, 1-cycle latency):
  - dcache_ack_valid has absolute priority: rf_we=(ack_rd!=0), rf_dest=ack data, rf_dest_long=1; clears scoreboard[ack_rd].
  - Otherwise an accepted ALU request writes rf_we=(alu_rd!=0), rf_dest=alu_data, rf_dest_long=alu_long.
  - When no write occurs, rf_we=0 and the other rf_* outputs hold.
- alu_retry (combinational) = INIT | dcache_ack_valid | scoreboard[alu_rd].
  - The scoreboard term blocks WAW against an outstanding load.
  - Writes to x0 are accepted and dropped.
- ld_issue_retry (combinational) = INIT | scoreboard[ld_issue_rd].
  - Retry holds even if an ack clears that register in the same cycle.
- Scoreboard:
  - An accepted load with rd!=0 sets scoreboard[rd] at the clock edge.
  - A set and a clear of different registers in the same cycle both take effect.
  - x0 is never pending.
- ld_pending = OR of the scoreboard (registered view).
- dec_stall = INIT | dec_valid & (hit(rs1) | hit(rs2)), where hit(r) = r!=0 & (scoreboard[r] | inflight(r)).
  - inflight(r) = rf_we & rf_rd==r & the registered write came from a dcache ack; this covers the cycle the ack is in the output register.
- dcache ack for a register not pending: written normally, scoreboard unchanged (no error).

Optional Feature:
RF_WB_PERF_EN defined:
- Adds outputs perf_alu_retry_cnt [31:0] and perf_dec_stall_cnt [31:0].
- perf_alu_retry_cnt counts RUN cycles with alu_valid&alu_retry.
- perf_dec_stall_cnt counts RUN cycles with dec_valid&dec_stall.
- Both counters saturate at 32'hFFFFFFFF and are reset to 0.

Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Release reset -> rf_we=1 for 32 cycles, rf_rd=0..31, rf_dest=0; init_busy falls after cycle 32; all retries high during sweep.
- RUN, alu_valid, rd=5, data=0x1234, long=0 -> next cycle rf_we=1, rf_rd=5, rf_dest=0x1234, rf_dest_long=0; alu_retry=0.
- Same cycle: ALU rd=3 and dcache ack rd=7 data=0xAA -> alu_retry=1, next cycle writes rd=7 data=0xAA long=1; ALU retried and accepted the following cycle.
- Issue load rd=9; decode rs2=9 -> dec_stall=1 until the cycle after the ack rd=9 writes (inflight); ALU rd=9 retried while pending; second load rd=9 retried.
- Load to rd=0 and ALU to rd=0 -> scoreboard unchanged, rf_we=0, no stall on rs1=0.
- Reset pulled low mid-RUN with loads pending -> ld_pending=0, init sweep restarts from rf_rd=0.

Source files
------------

// File: rtl/rf_wb_sched.sv
// Register-file write-port scheduler with load scoreboard and reset-time zeroing sweep.
// Define RF_WB_PERF_EN to add saturating retry/stall performance counters.
module rf_wb_sched #(
    parameter int NREGS = 32,
    parameter int RW    = 5,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [RW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            alu_long,
    output logic            alu_retry,
    input  logic            ld_issue_valid,
    input  logic [RW-1:0]   ld_issue_rd,
    output logic            ld_issue_retry,
    input  logic            dcache_ack_valid,
    input  logic [RW-1:0]   dcache_ack_rd,
    input  logic [XLEN-1:0] dcache_ack_data,
    input  logic            dec_valid,
    input  logic [RW-1:0]   dec_rs1,
    input  logic [RW-1:0]   dec_rs2,
    output logic            dec_stall,
    output logic            rf_we,
    output logic [RW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_dest,
    output logic            rf_dest_long,
    output logic            init_busy,
    output logic            ld_pending
`ifdef RF_WB_PERF_EN
    ,
    output logic [31:0]     perf_alu_retry_cnt,
    output logic [31:0]     perf_dec_stall_cnt
`endif
);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [RW-1:0]     cnt;
    logic [RW-1:0]     cnt_next;
    logic [NREGS-1:0]  sb;
    logic [NREGS-1:0]  sb_next;
    logic              rf_we_next;
    logic [RW-1:0]     rf_rd_next;
    logic [XLEN-1:0]   rf_dest_next;
    logic              rf_long_next;
    logic              rf_from_ack;
    logic              rf_from_ack_next;
    logic              in_init;
    logic              alu_accept;
    logic              ld_accept;
    logic              hit1;
    logic              hit2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_INIT;
            cnt          <= '0;
            sb           <= '0;
            rf_we        <= 1'b0;
            rf_rd        <= '0;
            rf_dest      <= '0;
            rf_dest_long <= 1'b0;
            rf_from_ack  <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            sb           <= sb_next;
            rf_we        <= rf_we_next;
            rf_rd        <= rf_rd_next;
            rf_dest      <= rf_dest_next;
            rf_dest_long <= rf_long_next;
            rf_from_ack  <= rf_from_ack_next;
        end
    end

    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        sb_next          = sb;
        rf_we_next       = 1'b0;
        rf_rd_next       = rf_rd;
        rf_dest_next     = rf_dest;
        rf_long_next     = rf_dest_long;
        rf_from_ack_next = 1'b0;

        in_init        = (state == S_INIT);
        init_busy      = in_init;
        ld_pending     = |sb;
        alu_retry      = in_init | dcache_ack_valid | sb[alu_rd];
        ld_issue_retry = in_init | sb[ld_issue_rd];
        alu_accept     = alu_valid & ~alu_retry;
        ld_accept      = ld_issue_valid & ~ld_issue_retry;

        // A load value sitting in the output register is not yet readable from the regfile.
        hit1 = (dec_rs1 != '0) &&
               (sb[dec_rs1] || (rf_we && rf_from_ack && (rf_rd == dec_rs1)));
        hit2 = (dec_rs2 != '0) &&
               (sb[dec_rs2] || (rf_we && rf_from_ack && (rf_rd == dec_rs2)));
        dec_stall = in_init | (dec_valid & (hit1 | hit2));

        case (state)
            S_INIT: begin
                rf_we_next   = 1'b1;
                rf_rd_next   = cnt;
                rf_dest_next = '0;
                rf_long_next = 1'b1;
                cnt_next     = cnt + RW'(1);
                if (cnt == RW'(NREGS - 1)) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (dcache_ack_valid) begin
                    rf_we_next             = (dcache_ack_rd != '0);
                    rf_rd_next             = dcache_ack_rd;
                    rf_dest_next           = dcache_ack_data;
                    rf_long_next           = 1'b1;
                    rf_from_ack_next       = 1'b1;
                    sb_next[dcache_ack_rd] = 1'b0;
                end else if (alu_accept) begin
                    rf_we_next   = (alu_rd != '0);
                    rf_rd_next   = alu_rd;
                    rf_dest_next = alu_data;
                    rf_long_next = alu_long;
                end
                if (ld_accept && (ld_issue_rd != '0)) begin
                    sb_next[ld_issue_rd] = 1'b1;
                end
            end
            default: begin
                state_next = S_INIT;
            end
        endcase

        sb_next[0] = 1'b0;
    end

`ifdef RF_WB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_alu_retry_cnt <= '0;
            perf_dec_stall_cnt <= '0;
        end else if (state == S_RUN) begin
            if (alu_valid && alu_retry && (perf_alu_retry_cnt != 32'hFFFF_FFFF)) begin
                perf_alu_retry_cnt <= perf_alu_retry_cnt + 32'd1;
            end
            if (dec_valid && dec_stall && (perf_dec_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_dec_stall_cnt <= perf_dec_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
